// File: rtl/mips_controller.sv
// Multicycle MIPS control unit.
// Decodes op/funct from the instruction register and steps each instruction
// through fetch, decode, execute, memory and write-back states, driving the
// datapath control inputs and the off-chip memory write strobe.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset to FETCH
//   op, funct           instruction fields [31:26] and [5:0]
//   zero                ALU zero flag (used by the datapath through pcwritecond)
//   alusrca, alusrcb    ALU operand selects
//   pcwrite, pcwritecond, pcsource   PC update controls
//   memtoreg, regdst, iord           datapath muxes
//   regwrite, irwrite, memwrite      write enables
//   alucontrol          ALU operation
//   illegal             one-cycle flag for an unsupported op/funct in DECODE
//   state               current state encoding
module mips_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic [1:0] pcsource,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic       regwrite,
    output logic       irwrite,
    output logic       memwrite,
    output logic [3:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StOriEx   = 4'd10,
        StImmWb   = 4'd11,
        StJEx     = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;
    localparam logic [3:0] AluSll = 4'b1000;
    localparam logic [3:0] AluSrl = 4'b1001;

    state_e     r_state;
    state_e     w_state_next;
    logic [3:0] w_funct_alu;
    logic       w_funct_ok;
    logic       w_op_ok;

    // R-type funct decode, shared by DECODE (legality) and RTYPEEX (ALU op).
    always_comb begin
        w_funct_alu = AluAdd;
        w_funct_ok  = 1'b1;
        case (funct)
            6'b100000: w_funct_alu = AluAdd;
            6'b100010: w_funct_alu = AluSub;
            6'b100100: w_funct_alu = AluAnd;
            6'b100101: w_funct_alu = AluOr;
            6'b100111: w_funct_alu = AluNor;
            6'b101010: w_funct_alu = AluSlt;
            6'b000000: w_funct_alu = AluSll;
            6'b000010: w_funct_alu = AluSrl;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OpRtype:                                  w_op_ok = w_funct_ok;
            OpLw, OpSw, OpBeq, OpAddi, OpOri, OpJ:    w_op_ok = 1'b1;
            default:                                  w_op_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = StFetch;
        case (r_state)
            StFetch:  w_state_next = StDecode;
            StDecode: begin
                if (w_op_ok) begin
                    case (op)
                        OpLw, OpSw: w_state_next = StMemAdr;
                        OpRtype:    w_state_next = StRtypeEx;
                        OpBeq:      w_state_next = StBeqEx;
                        OpAddi:     w_state_next = StAddiEx;
                        OpOri:      w_state_next = StOriEx;
                        OpJ:        w_state_next = StJEx;
                        default:    w_state_next = StFetch;
                    endcase
                end
            end
            StMemAdr: begin
                if (op == OpLw) begin
                    w_state_next = StMemRd;
                end else if (op == OpSw) begin
                    w_state_next = StMemWr;
                end
            end
            StMemRd:   w_state_next = StMemWb;
            StRtypeEx: w_state_next = StRtypeWb;
            StAddiEx:  w_state_next = StImmWb;
            StOriEx:   w_state_next = StImmWb;
            default:   w_state_next = StFetch;
        endcase
    end

    // Output logic
    always_comb begin
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        pcsource    = 2'b00;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        iord        = 1'b0;
        regwrite    = 1'b0;
        irwrite     = 1'b0;
        memwrite    = 1'b0;
        alucontrol  = AluAdd;
        illegal     = 1'b0;
        case (r_state)
            StFetch: begin
                irwrite = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
            end
            StDecode: begin
                // Precompute the branch target into ALUOut.
                alusrcb = 2'b11;
                illegal = ~w_op_ok;
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StMemRd: iord = 1'b1;
            StMemWb: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            StRtypeEx: begin
                alusrca    = 1'b1;
                alucontrol = w_funct_alu;
            end
            StRtypeWb: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            StBeqEx: begin
                alusrca     = 1'b1;
                alucontrol  = AluSub;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StOriEx: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = AluOr;
            end
            StImmWb: regwrite = 1'b1;
            StJEx: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            default: ;
        endcase
        // Reset masks every strobe, even though the state already reads FETCH.
        if (reset) begin
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            irwrite     = 1'b0;
            regwrite    = 1'b0;
            memwrite    = 1'b0;
            illegal     = 1'b0;
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_mips_controller.sv
module tb_mips_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       memtoreg;
    logic       regdst;
    logic       iord;
    logic       regwrite;
    logic       irwrite;
    logic       memwrite;
    logic [3:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    mips_controller dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .pcsource    (pcsource),
        .memtoreg    (memtoreg),
        .regdst      (regdst),
        .iord        (iord),
        .regwrite    (regwrite),
        .irwrite     (irwrite),
        .memwrite    (memwrite),
        .alucontrol  (alucontrol),
        .illegal     (illegal),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pcwrite, pcwritecond, irwrite, regwrite, memwrite, illegal
    function automatic logic [5:0] enables();
        return {pcwrite, pcwritecond, irwrite, regwrite, memwrite, illegal};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next sampling point and check the state reached.
    task automatic step(input string tag, input logic [3:0] exp_state);
        @(negedge clk);
        check_eq(tag, 32'(state), 32'(exp_state));
    endtask

    logic [5:0] rt_funct [3];
    logic [3:0] rt_alu   [3];

    initial begin
        rt_funct[0] = 6'b100010; rt_alu[0] = 4'b0110;
        rt_funct[1] = 6'b101010; rt_alu[1] = 4'b0111;
        rt_funct[2] = 6'b000010; rt_alu[2] = 4'b1001;

        reset = 1'b1;
        op    = 6'b100011;
        funct = 6'b000000;
        zero  = 1'b0;

        // Reset held for three cycles: state 0, all strobes low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_state", 32'(state), 32'd0);
            check_eq("rst_enables", 32'(enables()), 32'd0);
        end
        reset = 1'b0;
        #1;
        check_eq("fetch_pcwrite", 32'(pcwrite), 32'd1);
        check_eq("fetch_irwrite", 32'(irwrite), 32'd1);
        check_eq("fetch_alusrcb", 32'(alusrcb), 32'd1);

        // lw: 0,1,2,3,4,0
        step("lw_s1", 4'd1);
        check_eq("decode_alusrcb", 32'(alusrcb), 32'd3);
        check_eq("lw_dec_regwrite", 32'(regwrite), 32'd0);
        step("lw_s2", 4'd2);
        check_eq("lw_adr_srcs", 32'({alusrca, alusrcb, alucontrol}), 32'b1_10_0010);
        step("lw_s3", 4'd3);
        check_eq("lw_rd_iord", 32'(iord), 32'd1);
        check_eq("lw_rd_memtoreg", 32'({memtoreg, regwrite}), 32'd0);
        step("lw_s4", 4'd4);
        check_eq("lw_wb", 32'({memtoreg, regwrite, regdst}), 32'b110);
        step("lw_s0", 4'd0);

        // sw: 0,1,2,5,0
        op = 6'b101011;
        step("sw_s1", 4'd1);
        step("sw_s2", 4'd2);
        check_eq("sw_adr_memwrite", 32'(memwrite), 32'd0);
        step("sw_s5", 4'd5);
        check_eq("sw_wr", 32'({iord, memwrite}), 32'b11);
        step("sw_s0", 4'd0);
        check_eq("sw_fetch_memwrite", 32'(memwrite), 32'd0);

        // R-type: sub, slt, srl
        op = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            funct = rt_funct[i];
            step("rt_s1", 4'd1);
            step("rt_s6", 4'd6);
            check_eq("rt_alucontrol", 32'(alucontrol), 32'(rt_alu[i]));
            check_eq("rt_ex_srcs", 32'({alusrca, alusrcb}), 32'b100);
            step("rt_s7", 4'd7);
            check_eq("rt_wb", 32'({regwrite, regdst, memtoreg}), 32'b110);
            step("rt_s0", 4'd0);
        end

        // beq with zero=1 then zero=0
        op = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            step("beq_s1", 4'd1);
            step("beq_s8", 4'd8);
            check_eq("beq_ctl", 32'({pcwritecond, pcsource, alucontrol, pcwrite}),
                     32'b1_01_0110_0);
            step("beq_s0", 4'd0);
        end
        zero = 1'b0;

        // j
        op = 6'b000010;
        step("j_s1", 4'd1);
        step("j_s12", 4'd12);
        check_eq("j_ctl", 32'({pcwrite, pcsource}), 32'b1_10);
        step("j_s0", 4'd0);

        // ori
        op = 6'b001101;
        step("ori_s1", 4'd1);
        step("ori_s10", 4'd10);
        check_eq("ori_alu", 32'({alusrca, alusrcb, alucontrol}), 32'b1_10_0001);
        step("ori_s11", 4'd11);
        check_eq("ori_wb", 32'({regwrite, regdst, memtoreg}), 32'b100);
        step("ori_s0", 4'd0);

        // addi
        op = 6'b001000;
        step("addi_s1", 4'd1);
        step("addi_s9", 4'd9);
        check_eq("addi_alu", 32'(alucontrol), 32'b0010);
        step("addi_s11", 4'd11);
        step("addi_s0", 4'd0);

        // Illegal opcode, then illegal R-type funct
        op = 6'b111111;
        step("ill_op_s1", 4'd1);
        check_eq("ill_op_flag", 32'(enables()), 32'b000001);
        step("ill_op_s0", 4'd0);
        check_eq("ill_op_clear", 32'(illegal), 32'd0);
        op    = 6'b000000;
        funct = 6'b001111;
        step("ill_fn_s1", 4'd1);
        check_eq("ill_fn_flag", 32'(enables()), 32'b000001);
        step("ill_fn_s0", 4'd0);
        check_eq("ill_fn_clear", 32'(illegal), 32'd0);

        // Reset asserted during MEMWR kills memwrite at once.
        op = 6'b101011;
        step("rst_sw_s1", 4'd1);
        step("rst_sw_s2", 4'd2);
        step("rst_sw_s5", 4'd5);
        check_eq("rst_sw_pre", 32'(memwrite), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rst_sw_memwrite", 32'(memwrite), 32'd0);
        check_eq("rst_sw_state", 32'(state), 32'd0);
        check_eq("rst_sw_enables", 32'(enables()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("post_rst_s1", 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
